// File: rtl/bcla_pkg.sv
// Shared types and helpers for the 4-bit block carry-lookahead adder slice.
// Also consumed by the higher-level lookahead unit that chains slices via {g,p}.
package bcla_pkg;

    // Slice width; the lookahead equations below are written out for exactly 4 bits.
    localparam int unsigned GRP_W = 4;

    // Generate/propagate pair, used both per bit and per group.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Per-bit generate/propagate terms from one bit of each operand.
    function automatic gp_t gp_bit(input logic a, input logic b);
        gp_t r;
        r.g = a & b;
        r.p = a ^ b;
        return r;
    endfunction

    // Carry out of a group given its {g,p} and the carry into it.
    function automatic logic gp_carry(input gp_t gp, input logic c);
        return gp.g | (gp.p & c);
    endfunction

endpackage

// File: rtl/bcla_cla_unit.sv
// Combinational lookahead core: four per-bit {g,p} terms plus c0 produce
// the internal carries c0..c3 and the group generate/propagate.
// Every carry is a flat two-level sum of products; nothing ripples.
module bcla_cla_unit
    import bcla_pkg::*;
(
    input  gp_t  [GRP_W-1:0] bit_gp,
    input  logic             c0,
    output logic [GRP_W-1:0] carry_c,
    output gp_t              grp_c
);

    logic [GRP_W-1:0] gb;
    logic [GRP_W-1:0] pb;

    // Unpack the per-bit pairs into plain generate/propagate vectors.
    always_comb begin
        gb = '0;
        pb = '0;
        for (int i = 0; i < GRP_W; i++) begin
            gb[i] = bit_gp[i].g;
            pb[i] = bit_gp[i].p;
        end
    end

    // Flat SOP carries; the group terms deliberately exclude c0 so a parent
    // unit can combine slices before the carry into this slice is known.
    always_comb begin
        carry_c    = '0;
        grp_c      = '0;

        carry_c[0] = c0;
        carry_c[1] = gb[0]
                   | (pb[0] & c0);
        carry_c[2] = gb[1]
                   | (pb[1] & gb[0])
                   | (pb[1] & pb[0] & c0);
        carry_c[3] = gb[2]
                   | (pb[2] & gb[1])
                   | (pb[2] & pb[1] & gb[0])
                   | (pb[2] & pb[1] & pb[0] & c0);

        grp_c.g    = gb[3]
                   | (pb[3] & gb[2])
                   | (pb[3] & pb[2] & gb[1])
                   | (pb[3] & pb[2] & pb[1] & gb[0]);
        grp_c.p    = pb[3] & pb[2] & pb[1] & pb[0];
    end

endmodule

// File: rtl/bcla_adder_4.sv
// 4-bit block carry-lookahead adder slice: sum = (a+b+c_in) mod 16 plus
// group generate/propagate for a parent lookahead unit.
// Outputs are registered (latency 1) unless BCLA_REG_BYPASS_EN is defined,
// in which case sum/g/p are purely combinational and clk/rst are unused.
// Carry-out is not produced here; the parent forms it as g | (p & c_in).
module bcla_adder_4
    import bcla_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [GRP_W-1:0] sum,
    output logic             g,
    output logic             p,
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             c_in
);

    gp_t  [GRP_W-1:0] bit_gp;
    logic [GRP_W-1:0] carry_c;
    gp_t              grp_c;
    logic [GRP_W-1:0] sum_c;

    // Per-bit generate/propagate terms.
    always_comb begin
        bit_gp = '0;
        for (int i = 0; i < GRP_W; i++) begin
            bit_gp[i] = gp_bit(a[i], b[i]);
        end
    end

    bcla_cla_unit u_cla (
        .bit_gp  (bit_gp),
        .c0      (c_in),
        .carry_c (carry_c),
        .grp_c   (grp_c)
    );

    // Sum bit i is the bit propagate XOR the carry into bit i.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < GRP_W; i++) begin
            sum_c[i] = bit_gp[i].p ^ carry_c[i];
        end
    end

`ifdef BCLA_REG_BYPASS_EN
    // Latency-0 build: outputs follow the operands directly.
    assign sum = sum_c;
    assign g   = grp_c.g;
    assign p   = grp_c.p;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`else
    // Capture the combinational result every rising edge; reset clears at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            g   <= 1'b0;
            p   <= 1'b0;
        end else begin
            sum <= sum_c;
            g   <= grp_c.g;
            p   <= grp_c.p;
        end
    end
`endif

endmodule

// File: tb/tb_bcla_adder_4.sv
// Self-checking bench for bcla_adder_4: directed literal vectors, async reset,
// exhaustive 512-vector sweep and random vectors against an arithmetic model.
// Also handles the BCLA_REG_BYPASS_EN (latency-0) build.
module tb_bcla_adder_4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] a      = 4'd7;
    logic [3:0] b      = 4'd8;
    logic       c_in   = 1'b0;
    logic [3:0] sum;
    logic       g;
    logic       p;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        chk_en  = 1'b0;

    always #5 clk = ~clk;

    bcla_adder_4 dut (
        .clk  (clk),
        .rst  (rst),
        .sum  (sum),
        .g    (g),
        .p    (p),
        .a    (a),
        .b    (b),
        .c_in (c_in)
    );

    // Arithmetic reference: returns {G, P, sum}. G means a+b alone overflows
    // 4 bits; P means a+b is exactly 15, so any carry in passes straight out.
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mc);
        int unsigned s;
        int unsigned ab;
        logic        gg;
        logic        pp;
        ab = 32'(ma) + 32'(mb);
        s  = ab + 32'(mc);
        gg = (ab > 32'd15);
        pp = (ab == 32'd15);
        return {gg, pp, 4'(s)};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (a=%0d b=%0d c_in=%0d t=%0t)",
                     name, act, exp, a, b, c_in, $time);
        end
    endtask

    // Expected outputs and the operands they were derived from.
    logic [5:0] exp_q    = 6'd0;
    logic [3:0] exp_a    = 4'd0;
    logic [3:0] exp_b    = 4'd0;
    logic       exp_c    = 1'b0;
    logic       exp_live = 1'b0;

`ifdef BCLA_REG_BYPASS_EN
    always_comb begin
        exp_q    = model(a, b, c_in);
        exp_a    = a;
        exp_b    = b;
        exp_c    = c_in;
        exp_live = 1'b1;
    end
`else
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q    <= 6'd0;
            exp_live <= 1'b0;
        end else begin
            exp_q    <= model(a, b, c_in);
            exp_a    <= a;
            exp_b    <= b;
            exp_c    <= c_in;
            exp_live <= 1'b1;
        end
    end
`endif

    // Every cycle: outputs vs model, and {carry-out, sum} vs the 5-bit sum.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_gp_sum", 32'({g, p, sum}), 32'(exp_q));
            if (exp_live) begin
                check("cycle_cout_sum", 32'({g | (p & exp_c), sum}),
                      32'(exp_a) + 32'(exp_b) + 32'(exp_c));
            end
        end
    end

    // Apply one vector and compare against hand-computed literals.
    task automatic vec(input string name, input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic [3:0] esum, input logic eg,
                       input logic ep);
        @(posedge clk);
        #2;
        a    = va;
        b    = vb;
        c_in = vc;
`ifdef BCLA_REG_BYPASS_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
        check(name, 32'({g, p, sum}), 32'({eg, ep, esum}));
    endtask

    initial begin
        logic [5:0] exp_rst;

        // Reset state with nonzero operands present.
        #1;
`ifdef BCLA_REG_BYPASS_EN
        exp_rst = 6'b01_1111;
`else
        exp_rst = 6'd0;
`endif
        check("reset_state", 32'({g, p, sum}), 32'(exp_rst));
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        vec("v_1_2_0",  4'd1,  4'd2, 1'b0, 4'd3,  1'b0, 1'b0);
        vec("v_3_4_1",  4'd3,  4'd4, 1'b1, 4'd8,  1'b0, 1'b0);
        vec("v_5_6_0",  4'd5,  4'd6, 1'b0, 4'hB,  1'b0, 1'b0);
        vec("v_7_8_1",  4'd7,  4'd8, 1'b1, 4'd0,  1'b0, 1'b1);
        vec("v_7_8_0",  4'd7,  4'd8, 1'b0, 4'd15, 1'b0, 1'b1);
        vec("v_15_1_0", 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);

        // Mid-cycle reset pulse: outputs must clear without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
`ifdef BCLA_REG_BYPASS_EN
        exp_rst = 6'b10_0000;
`else
        exp_rst = 6'd0;
`endif
        check("async_rst", 32'({g, p, sum}), 32'(exp_rst));
        // Hold across edges, then release; the per-cycle check covers the
        // interval before the first capture edge.
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b0;
        a    = 4'd3;
        b    = 4'd4;
        c_in = 1'b1;
        @(negedge clk);
        #1;
        check("hold_after_rst", 32'({g, p, sum}), 32'(exp_rst == 6'd0 ? 6'd0 : model(a, b, c_in)));
        @(posedge clk);
        #1;
        check("first_capture", 32'({g, p, sum}), 32'({1'b0, 1'b0, 4'd8}));

        // Exhaustive sweep of every {a, b, c_in}.
        for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            #2;
            {a, b, c_in} = 9'(i);
        end

        // Random vectors.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            a    = 4'($urandom_range(15, 0));
            b    = 4'($urandom_range(15, 0));
            c_in = 1'($urandom_range(1, 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
